// File: rtl/reg_shift_sequencer.sv
// reg_shift_sequencer: iterative register-specified operand-2 shifter (LSL/LSR/ASR/ROR, ARM amount semantics)
module reg_shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] val_Rm,
  input  logic [1:0]       shift_type,
  input  logic [7:0]       shift_amt,
  input  logic             carry_in,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [5:0] STEP6 = 6'(STEP);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, sh;
  logic             c_q, c_d, csh, ror_z;
  logic [1:0]       ty_q, ty_d;
  logic [5:0]       rem_q, rem_d, n;
  always_comb begin
    n = shift_amt == 8'd0 ? 6'd0 :
        shift_type == 2'b11 ? {1'b0, shift_amt[4:0]} :
        shift_amt > 8'd33 ? 6'd33 : shift_amt[5:0];
    ror_z = shift_type == 2'b11 && shift_amt != 8'd0 && shift_amt[4:0] == 5'd0;
    sh = r_q;
    csh = c_q;
    // one-bit steps, only the first min(rem,STEP) of them take effect
    for (int i = 0; i < STEP; i++) begin
      if (6'(i) < rem_q) begin
        csh = ty_q == 2'b00 ? sh[WIDTH-1] : sh[0];
        sh = ty_q == 2'b00 ? {sh[WIDTH-2:0], 1'b0} :
             ty_q == 2'b01 ? {1'b0, sh[WIDTH-1:1]} :
             ty_q == 2'b10 ? {sh[WIDTH-1], sh[WIDTH-1:1]} : {sh[0], sh[WIDTH-1:1]};
      end
    end
    state_d = state_q;
    r_d = r_q;
    c_d = c_q;
    ty_d = ty_q;
    rem_d = rem_q;
    if (flush && state_q != IDLE) begin
      state_d = IDLE;
    end else if (state_q == IDLE && start_valid) begin
      r_d = val_Rm;
      c_d = ror_z ? val_Rm[WIDTH-1] : carry_in;
      ty_d = shift_type;
      rem_d = n;
      state_d = n == 6'd0 ? DONE : SHIFT;
    end else if (state_q == SHIFT) begin
      r_d = sh;
      c_d = csh;
      rem_d = rem_q > STEP6 ? rem_q - STEP6 : 6'd0;
      state_d = rem_q > STEP6 ? SHIFT : DONE;
    end else if (state_q == DONE && done_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      r_q <= '0;
      c_q <= 1'b0;
      ty_q <= 2'b00;
      rem_q <= 6'd0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      c_q <= c_d;
      ty_q <= ty_d;
      rem_q <= rem_d;
    end
  end
  assign start_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign done_valid = state_q == DONE;
  assign result = r_q;
  assign carry_out = c_q;
endmodule

// File: tb/tb_reg_shift_sequencer.sv
// tb_reg_shift_sequencer: directed vectors with hand-computed results, carries and latencies (STEP=4)
`timescale 1ns/1ps
module tb_reg_shift_sequencer;
  logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, start_valid = 1'b0, done_ready = 1'b0, carry_in = 1'b0;
  logic [31:0] val_Rm = '0;
  logic [1:0]  shift_type = 2'b00;
  logic [7:0]  shift_amt = '0;
  logic        start_ready, done_valid, carry_out, busy;
  logic [31:0] result;
  int checks = 0, failures = 0;
  reg_shift_sequencer #(.WIDTH(32), .STEP(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start_valid(start_valid), .start_ready(start_ready),
    .val_Rm(val_Rm), .shift_type(shift_type), .shift_amt(shift_amt), .carry_in(carry_in),
    .done_valid(done_valid), .done_ready(done_ready), .result(result), .carry_out(carry_out), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [31:0] rm, input logic [1:0] ty, input logic [7:0] amt,
                        input logic cin, input logic [31:0] er, input logic ec, input int ecyc, input int hold);
    int cyc;
    val_Rm = rm;
    shift_type = ty;
    shift_amt = amt;
    carry_in = cin;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    cyc = 1;
    while (!done_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " cycles"}, 32'(cyc), 32'(ecyc));
    chk({tag, " result"}, result, er);
    chk({tag, " carry"}, {31'd0, carry_out}, {31'd0, ec});
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, " hold valid"}, {31'd0, done_valid}, 32'd1);
      chk({tag, " hold result"}, result, er);
      chk({tag, " hold carry"}, {31'd0, carry_out}, {31'd0, ec});
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    chk({tag, " release"}, {30'd0, done_valid, start_ready}, 32'd1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset outs", {27'd0, start_ready, busy, done_valid, carry_out, 1'b0}, 32'h10);
    chk("reset result", result, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    run_op("lsl4", 32'h00000001, 2'b00, 8'd4, 1'b0, 32'h00000010, 1'b0, 2, 0);
    run_op("amt0 lsl", 32'hDEADBEEF, 2'b00, 8'd0, 1'b1, 32'hDEADBEEF, 1'b1, 1, 0);
    run_op("amt0 ror", 32'hDEADBEEF, 2'b11, 8'd0, 1'b1, 32'hDEADBEEF, 1'b1, 1, 0);
    run_op("lsr32", 32'h80000000, 2'b01, 8'd32, 1'b0, 32'h0, 1'b1, 9, 0);
    run_op("lsr40", 32'h80000000, 2'b01, 8'd40, 1'b1, 32'h0, 1'b0, 10, 0);
    run_op("asr200", 32'h80000000, 2'b10, 8'd200, 1'b0, 32'hFFFFFFFF, 1'b1, 10, 0);
    run_op("lsl33", 32'h00000001, 2'b00, 8'd33, 1'b1, 32'h0, 1'b0, 10, 0);
    run_op("ror33", 32'h00000001, 2'b11, 8'd33, 1'b0, 32'h80000000, 1'b1, 2, 0);
    run_op("ror32", 32'h00000001, 2'b11, 8'd32, 1'b1, 32'h00000001, 1'b0, 1, 0);
    run_op("asr5", 32'h80000000, 2'b10, 8'd5, 1'b1, 32'hFC000000, 1'b0, 3, 0);
    run_op("ror4", 32'h0000000F, 2'b11, 8'd4, 1'b0, 32'hF0000000, 1'b1, 2, 0);
    run_op("lsl1", 32'h80000001, 2'b00, 8'd1, 1'b0, 32'h00000002, 1'b1, 2, 0);
    run_op("lsr3", 32'h0000000F, 2'b01, 8'd3, 1'b0, 32'h00000001, 1'b1, 2, 0);
    run_op("ror31", 32'h00000002, 2'b11, 8'd31, 1'b1, 32'h00000004, 1'b0, 9, 0);
    run_op("stall", 32'h12345678, 2'b01, 8'd8, 1'b0, 32'h00123456, 1'b0, 3, 3);
    val_Rm = 32'h80000000;
    shift_type = 2'b01;
    shift_amt = 8'd32;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    chk("flush pre busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush state", {29'd0, busy, done_valid, start_ready}, 32'd1);
    repeat (10) begin
      @(posedge clk); #1;
      chk("flush no done", {31'd0, done_valid}, 32'd0);
    end
    carry_in = 1'b1;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rst mid state", {29'd0, busy, done_valid, start_ready}, 32'd1);
    chk("rst mid result", result, 32'h0);
    chk("rst mid carry", {31'd0, carry_out}, 32'd0);
    repeat (10) begin
      @(posedge clk); #1;
      chk("rst no done", {31'd0, done_valid}, 32'd0);
    end
    run_op("post rst", 32'h00000003, 2'b00, 8'd2, 1'b0, 32'h0000000C, 1'b0, 2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
